lut_ram_mp: RTL
===============

LUT_RAM_MP -- requirements
Module: lut_ram_mp

Interface
REQ-001 SHALL have parameter LUT_WIDTH, default XLEN (32), bits per word; multiple of 8.
REQ-002 SHALL have parameter LUT_DEPTH, default 256, number of words; any value >= 2, not required to be a power of 2.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2, number of independent combinational read ports; range 1..4.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  $clog2(LUT_DEPTH)  write address.
REQ-009 wr_data  input  LUT_WIDTH  write data.
REQ-010 wr_strb  input  LUT_WIDTH/8  byte write enables; bit i gates wr_data[8i+7:8i].
REQ-011 rd_addr  input  NUM_RD_PORTS x $clog2(LUT_DEPTH)  per-port read address.
REQ-012 rd_data  output  NUM_RD_PORTS x LUT_WIDTH  per-port read data, combinational.
REQ-013 clr_req  input  1  pulse requesting a full memory clear.
REQ-014 busy  output  1  high while a clear is in progress.

Function
REQ-015 Write: on rising clk with wr_en=1 and busy=0, bytes of mem[wr_addr] with wr_strb bit set take wr_data; other bytes unchanged.
REQ-016 wr_strb=0 with wr_en=1 leaves memory unchanged.
REQ-017 wr_addr >= LUT_DEPTH with wr_en=1 is ignored; no memory word changes.
REQ-018 Read: rd_data[p] = mem[rd_addr[p]] combinationally, zero clock latency; ports independent, same address on several ports allowed.
REQ-019 rd_addr[p] >= LUT_DEPTH returns all zeros.
REQ-020 Clear FSM states: CLEAR, READY.
REQ-021 CLEAR: each cycle writes zero to mem[clr_cnt]; clr_cnt increments; at clr_cnt = LUT_DEPTH-1 writes zero, clr_cnt wraps to 0, next state READY.
REQ-022 READY: clr_req=1 at rising clk -> CLEAR with clr_cnt=0; else stay READY.
REQ-023 Clear takes exactly LUT_DEPTH cycles; busy=1 in CLEAR, 0 in READY.
REQ-024 While busy=1: wr_en ignored, clr_req ignored (no restart), all rd_data ports return zeros.
REQ-025 clr_req and wr_en asserted same edge in READY: write is performed, then clear begins next cycle (write later zeroed).

Reset
REQ-026 rst_n low asynchronously forces state CLEAR, clr_cnt=0, busy=1; rd_data = zeros immediately.
REQ-027 On rst_n deassertion the clear runs; busy falls LUT_DEPTH cycles after the first rising clk with rst_n high.
REQ-028 Reset mid-clear restarts the clear from address 0.
REQ-029 Memory array itself has no reset term; zeroing only via the CLEAR sequence.

Configuration
REQ-030 Macro LUT_RAM_MP_BYPASS_EN defined: rd_data[p] for rd_addr[p]=wr_addr with an accepted write in the same cycle returns write-first data (strobed bytes from wr_data, others from memory).
REQ-031 Macro undefined: same-cycle read of the written address returns the old contents; new data visible after the clock edge.

Structure
REQ-032 Shared package lut_ram_pkg SHALL hold the clear FSM state enum and LUT_RAM_MP default parameter constants; width from riscv_32i_defs_pkg::XLEN.
REQ-033 Sub-module lut_ram_clr_fsm SHALL contain the state register, clr_cnt and busy; lut_ram_mp holds array, write-strobe merge, read muxes, bypass.

Verification
REQ-034 Reset released, hold 256 cycles -> busy=1 for exactly 256 cycles, then 0; all reads of any address = 0x00000000.
REQ-035 Write 0xDEADBEEF strb 4'b1111 addr 5, then 0x000000AA strb 4'b0001 addr 5 -> port0 addr 5 reads 0xDEADBEAA.
REQ-036 Port0 addr 5, port1 addr 9 after writes 0x11111111/0x22222222 -> 0x11111111 and 0x22222222 same cycle.
REQ-037 Write 0xCAFEF00D addr 7 with rd_addr[0]=7 sampled before edge -> 0xCAFEF00D with LUT_RAM_MP_BYPASS_EN, 0x00000000 without.
REQ-038 clr_req pulse after writes, wr_en 0x12345678 addr 3 at cycle 10 of clear -> busy 256 cycles, reads 0 during clear, addr 3 reads 0 after.
REQ-039 rst_n low at cycle 100 of clear -> busy stays 1, clear restarts, busy falls 256 cycles after release.

Source files
------------

// File: rtl/lut_ram_pkg.sv
// Shared types and defaults for the multi-port LUT RAM and its clear sequencer.
package lut_ram_pkg;
    localparam int LUT_RAM_MP_WIDTH    = riscv_32i_defs_pkg::XLEN;
    localparam int LUT_RAM_MP_DEPTH    = 256;
    localparam int LUT_RAM_MP_RD_PORTS = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    // Depth need not be a power of two, so the address space can exceed the array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Base ISA definitions shared across the RV32I core blocks.
package riscv_32i_defs_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/lut_ram_clr_fsm.sv
// Clear sequencer: walks clr_cnt over every word after reset or a clr_req pulse.
module lut_ram_clr_fsm
    import lut_ram_pkg::*;
#(
    parameter int DEPTH = LUT_RAM_MP_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic [AW-1:0] clr_cnt,
    output logic          busy
);
    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            clr_cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = clr_cnt;
        case (state_q)
            CLEAR: begin
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = clr_cnt + 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy = (state_q == CLEAR);
endmodule

// File: rtl/lut_ram_mp.sv
// Multi-port LUT RAM: one byte-strobed write port, NUM_RD_PORTS combinational reads, self-clearing.
// Define LUT_RAM_MP_BYPASS_EN to forward same-cycle writes to matching reads (write-first).
module lut_ram_mp
    import lut_ram_pkg::*;
#(
    parameter int LUT_WIDTH    = LUT_RAM_MP_WIDTH,
    parameter int LUT_DEPTH    = LUT_RAM_MP_DEPTH,
    parameter int NUM_RD_PORTS = LUT_RAM_MP_RD_PORTS,
    localparam int AW          = $clog2(LUT_DEPTH),
    localparam int NB          = LUT_WIDTH / 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    wr_en,
    input  logic [AW-1:0]                           wr_addr,
    input  logic [LUT_WIDTH-1:0]                    wr_data,
    input  logic [NB-1:0]                           wr_strb,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]         rd_addr,
    output logic [NUM_RD_PORTS-1:0][LUT_WIDTH-1:0]  rd_data,
    input  logic                                    clr_req,
    output logic                                    busy
);
    logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
    logic [AW-1:0]        clr_cnt;
    logic                 wr_ok;
    logic [LUT_WIDTH-1:0] wr_word;

    lut_ram_clr_fsm #(.DEPTH(LUT_DEPTH)) u_clr_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .clr_cnt (clr_cnt),
        .busy    (busy)
    );

    // Merged word = old contents with strobed bytes replaced; also the bypass value.
    always_comb begin
        wr_ok   = wr_en && !busy && addr_in_range(32'(wr_addr), LUT_DEPTH);
        wr_word = wr_ok ? mem[wr_addr] : '0;
        for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (busy)       mem[clr_cnt] <= '0;
        else if (wr_ok) mem[wr_addr] <= wr_word;
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [LUT_WIDTH-1:0] word;
        always_comb begin
            word = '0;
            if (!busy && addr_in_range(32'(rd_addr[p]), LUT_DEPTH)) word = mem[rd_addr[p]];
`ifdef LUT_RAM_MP_BYPASS_EN
            if (wr_ok && rd_addr[p] == wr_addr) word = wr_word;
`endif
        end
        assign rd_data[p] = word;
    end
endmodule
